// File: rtl/uart_receiver.sv
// uart_receiver
//   Receive side of the UART link. Recovers 8N1 frames (start=0, 8 data bits
//   LSB first, stop=1) from an asynchronous serial line, each bit lasting
//   OVERSAMPLE b_tick pulses. Bits are sampled mid-bit. The received byte is
//   held for the consumer under a valid/read handshake. The block flags
//   framing errors and overrun errors.
//
//   Optional feature: define PARITY_EN to add an even-parity bit between the
//   data and stop bits. Without it, parity_error is tied to 0.
//
// Ports
//   clk            in   system clock, all logic on posedge
//   rst            in   synchronous reset, active-high
//   serial_in      in   asynchronous UART line, idles high
//   b_tick         in   one-clk pulse at OVERSAMPLE x baud rate
//   read_data      in   consumer pulse: byte taken, clears data_valid/overrun
//   data_out       out  last good byte received
//   data_valid     out  high from byte load until read_data
//   frame_error    out  one-clk pulse: stop bit sampled 0
//   overrun_error  out  sticky: byte overwritten while data_valid=1
//   parity_error   out  one-clk pulse: parity mismatch (PARITY_EN only)

module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       b_tick,
  input  logic       read_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       parity_error
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam int unsigned      BCNT_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [BCNT_W-1:0]  bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         dout_q, dout_d;
  logic               dv_q, dv_d;
  logic               fe_q, fe_d;
  logic               ovr_q, ovr_d;
  logic               load;
  logic               rx_s;
`ifdef PARITY_EN
  logic               par_q, par_d;
  logic               pe_q, pe_d;
`endif

  assign rx_s = sync_q[1];

  // State and datapath registers; the line synchronizer resets to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], serial_in};
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  // Next-state, counters, handshake and error flags
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    ovr_d   = ovr_q;
    fe_d    = 1'b0;
    load    = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif

    if (read_data && dv_q) begin
      dv_d  = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (b_tick && !rx_s) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end

      // Confirm the start bit at its midpoint; a high line means a glitch
      S_START: begin
        if (b_tick) begin
          if (tick_q == HALF_LAST) begin
            if (!rx_s) begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
      end

      // Counting from mid-start, each full bit period lands mid-bit
      S_DATA: begin
        if (b_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + BCNT_W'(1);
            if (bit_q == BCNT_W'(7)) begin
`ifdef PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
      end

`ifdef PARITY_EN
      S_PARITY: begin
        if (b_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
      end
`endif

      // A bad stop bit takes precedence over any parity result
      S_STOP: begin
        if (b_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
`ifdef PARITY_EN
              if (^{shift_q, par_q}) begin
                pe_d = 1'b1;
              end else begin
                load = 1'b1;
              end
`else
              load = 1'b1;
`endif
            end else begin
              fe_d    = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
      end

      // Held-low line: wait for idle so only one frame_error is raised
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A load overrides a simultaneous read; overrun only if the old byte was unread
    if (load) begin
      dout_d = shift_q;
      dv_d   = 1'b1;
      ovr_d  = read_data ? 1'b0 : (ovr_q | dv_q);
    end
  end

  assign data_out      = dout_q;
  assign data_valid    = dv_q;
  assign frame_error   = fe_q;
  assign overrun_error = ovr_q;
`ifdef PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Self-checking bench for uart_receiver. A table of frames (byte, stop bit,
//   read-after flag, expected outputs) is sent serially. Expected bytes go
//   into a scoreboard queue when a frame is driven. They are popped when the
//   DUT loads a byte. Hand-written sequences cover the start glitch, the
//   held-low break, reset mid-frame and (with PARITY_EN) the parity error.

module tb_uart_receiver;

  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 3;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       b_tick;
  logic       read_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       overrun_error;
  logic       parity_error;

  uart_receiver #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .b_tick       (b_tick),
    .read_data    (read_data),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .overrun_error(overrun_error),
    .parity_error (parity_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd;
    logic [7:0] exp_data;
    logic       exp_dv;
    int         exp_fe;
    logic       exp_ovr;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         div = 0;
  logic       dv_prev = 1'b0;
  logic [7:0] dout_prev = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe outputs at negedge, then schedule the next b_tick
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (data_valid && (!dv_prev || data_out != dout_prev)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_load: got data_out=0x%0h, expected no load", data_out);
      end else begin
        e = exp_q.pop_front();
        chk("load_data", int'(data_out), int'(e));
      end
    end
    dv_prev   = data_valid;
    dout_prev = data_out;
    if (frame_error)  fe_cnt++;
    if (parity_error) pe_cnt++;
    div    = (div == TICK_DIV - 1) ? 0 : div + 1;
    b_tick = (div == 0);
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      step();
      if (b_tick) k++;
    end
  endtask

  task automatic send_bit(input logic v);
    serial_in = v;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef PARITY_EN
  task automatic send_frame_badpar(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d));
    send_bit(1'b1);
  endtask
`endif

  task automatic pulse_read();
    read_data = 1'b1;
    step();
    read_data = 1'b0;
    step();
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic st, input logic rd,
                              input logic [7:0] ed, input logic edv, input int efe,
                              input logic eovr);
    vec_t v;
    v.data = d; v.stop = st; v.rd = rd;
    v.exp_data = ed; v.exp_dv = edv; v.exp_fe = efe; v.exp_ovr = eovr;
    return v;
  endfunction

  initial begin
    int fe0;
    vec_t v;
    logic [7:0] partial;

    rst = 1'b1; serial_in = 1'b1; read_data = 1'b0; b_tick = 1'b0;

    vq.push_back(mk(8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 0, 1'b0));
    vq.push_back(mk(8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 1'b0));
    vq.push_back(mk(8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 1'b0));
    vq.push_back(mk(8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 0, 1'b1));
    vq.push_back(mk(8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 1'b0));
    vq.push_back(mk(8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 1'b0));
    vq.push_back(mk(8'h80, 1'b0, 1'b0, 8'hFF, 1'b1, 1, 1'b0));
    vq.push_back(mk(8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 0, 1'b1));
    vq.push_back(mk(8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 0, 1'b0));

    // Reset state
    repeat (5) step();
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_frame_error", int'(frame_error), 0);
    chk("rst_overrun", int'(overrun_error), 0);
    chk("rst_parity", int'(parity_error), 0);
    rst = 1'b0;
    wait_ticks(20);

    // Table-driven frames
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      fe0 = fe_cnt;
      if (v.stop) exp_q.push_back(v.data);
      send_frame(v.data, v.stop);
      serial_in = 1'b1;
      wait_ticks(24);
      chk($sformatf("v%0d_data_out", i), int'(data_out), int'(v.exp_data));
      chk($sformatf("v%0d_data_valid", i), int'(data_valid), int'(v.exp_dv));
      chk($sformatf("v%0d_overrun", i), int'(overrun_error), int'(v.exp_ovr));
      chk($sformatf("v%0d_fe_pulses", i), fe_cnt - fe0, v.exp_fe);
      chk($sformatf("v%0d_pending", i), exp_q.size(), 0);
      if (v.rd) begin
        pulse_read();
        chk($sformatf("v%0d_rd_valid", i), int'(data_valid), 0);
        chk($sformatf("v%0d_rd_overrun", i), int'(overrun_error), 0);
      end
    end

    // Start glitch: low for 4 ticks only
    fe0 = fe_cnt;
    serial_in = 1'b0;
    wait_ticks(4);
    serial_in = 1'b1;
    wait_ticks(40);
    chk("glitch_valid", int'(data_valid), 0);
    chk("glitch_fe_pulses", fe_cnt - fe0, 0);

    // Bad stop, then line held low three more bit times: a single pulse
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    wait_ticks(3 * OS);
    serial_in = 1'b1;
    wait_ticks(24);
    chk("break_fe_pulses", fe_cnt - fe0, 1);
    chk("break_valid", int'(data_valid), 0);

    // Reset during bit 4 of 0x5A, then a clean 0x81
    fe0 = fe_cnt;
    partial = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    serial_in = partial[4];
    wait_ticks(OS / 2);
    rst = 1'b1;
    serial_in = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_valid", int'(data_valid), 0);
    wait_ticks(20);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    serial_in = 1'b1;
    wait_ticks(24);
    chk("after_rst_data_out", int'(data_out), 'h81);
    chk("after_rst_valid", int'(data_valid), 1);
    chk("after_rst_overrun", int'(overrun_error), 0);
    chk("after_rst_fe_pulses", fe_cnt - fe0, 0);
    pulse_read();

`ifdef PARITY_EN
    // Bad parity discards the byte; good parity delivers it
    fe0 = fe_cnt;
    send_frame_badpar(8'h07);
    serial_in = 1'b1;
    wait_ticks(24);
    chk("badpar_pulses", pe_cnt, 1);
    chk("badpar_valid", int'(data_valid), 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    serial_in = 1'b1;
    wait_ticks(24);
    chk("goodpar_data_out", int'(data_out), 'h07);
    chk("goodpar_valid", int'(data_valid), 1);
    chk("par_fe_pulses", fe_cnt - fe0, 0);
    chk("par_total_pulses", pe_cnt, 1);
`else
    chk("parity_pulses", pe_cnt, 0);
`endif

    chk("final_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
